// File: rtl/irq_vector_latch.sv
// Interrupt vector latch behind an 8-to-3 active-low priority encoder: synchronises and
// debounces {GS_bar, Y_bar}, latches the winning level and runs a req/ack/eoi handshake.
module irq_vector_latch #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [7:0]  VEC_BASE      = 8'h40
) (
    input  logic       clk,
    input  logic       rst_bar,
    input  logic       GS_bar,
    input  logic [2:0] Y_bar,
    input  logic       irq_ack,
    input  logic       eoi,
    output logic       irq_req,
    output logic [7:0] irq_vector,
    output logic       in_service,
    output logic       spurious
);

    // state  | meaning
    // IDLE   | waiting for a stable, valid encoder request
    // PEND   | vector presented, irq_req high, waiting for irq_ack
    // ACTIVE | level acknowledged and in service until eoi

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

    logic [3:0] sync_a;
    logic [3:0] s_q;
    logic [3:0] hold_val;
    logic [3:0] cnt;
    logic       stable;
    logic       valid;
    logic [2:0] level;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] level_q;
    logic [2:0] level_nxt;
    logic       spur_q;
    logic       spur_nxt;

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            sync_a <= 4'b1111;
            s_q    <= 4'b1111;
        end else begin
            sync_a <= {GS_bar, Y_bar};
            s_q    <= sync_a;
        end
    end

    // Any change restarts the run count; the value is only used once it has held CNT_MAX samples.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            hold_val <= 4'b1111;
            cnt      <= CNT_MAX;
        end else if (s_q != hold_val) begin
            hold_val <= s_q;
            cnt      <= 4'd1;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign stable = (cnt == CNT_MAX);
    assign valid  = stable & ~hold_val[3];
    assign level  = ~hold_val[2:0];

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            state   <= IDLE;
            level_q <= 3'd0;
            spur_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            level_q <= level_nxt;
            spur_q  <= spur_nxt;
        end
    end

    // irq_ack wins over withdrawal or a level update in the same cycle.
    always_comb begin
        state_nxt = state;
        level_nxt = level_q;
        spur_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    state_nxt = PEND;
                    level_nxt = level;
                end
            end
            PEND: begin
                if (irq_ack) begin
                    state_nxt = ACTIVE;
                end else if (stable && hold_val[3]) begin
                    state_nxt = IDLE;
                    spur_nxt  = 1'b1;
                end else if (valid && (level != level_q)) begin
                    level_nxt = level;
                end
            end
            ACTIVE: begin
                if (eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        irq_req    = (state == PEND);
        in_service = (state == ACTIVE);
        spurious   = spur_q;
        irq_vector = VEC_BASE + {5'd0, level_q};
    end

endmodule

// File: tb/tb_irq_vector_latch.sv
// Self-checking bench for irq_vector_latch: a sample-history model checked every cycle
// against two instances (default base and base 8'hFC), plus directed literal checks.
module tb_irq_vector_latch;

    localparam int S = 4;

    logic       clk;
    logic       rst_bar;
    logic       GS_bar;
    logic [2:0] Y_bar;
    logic       irq_ack;
    logic       eoi;
    logic       irq_req;
    logic [7:0] irq_vector;
    logic       in_service;
    logic       spurious;
    logic       fc_req;
    logic [7:0] fc_vector;
    logic       fc_in_service;
    logic       fc_spurious;

    int n_cmp = 0;
    int n_err = 0;
    int req_cnt = 0;

    irq_vector_latch u_dut (
        .clk(clk), .rst_bar(rst_bar), .GS_bar(GS_bar), .Y_bar(Y_bar),
        .irq_ack(irq_ack), .eoi(eoi), .irq_req(irq_req), .irq_vector(irq_vector),
        .in_service(in_service), .spurious(spurious)
    );

    irq_vector_latch #(.STABLE_CYCLES(4), .VEC_BASE(8'hFC)) u_fc (
        .clk(clk), .rst_bar(rst_bar), .GS_bar(GS_bar), .Y_bar(Y_bar),
        .irq_ack(irq_ack), .eoi(eoi), .irq_req(fc_req), .irq_vector(fc_vector),
        .in_service(fc_in_service), .spurious(fc_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: history of the input seen at each edge; the filter acts on the sample from
    // three edges back and calls it stable when the S samples ending there all agree.
    logic [3:0] hist[$];
    int         m_st;      // 0 idle, 1 pending, 2 in service
    int         m_lvl;
    bit         m_spur;

    function automatic logic [3:0] back(int i);
        int idx;
        idx = hist.size() - 1 - i;
        if (idx < 0) return 4'hF;
        return hist[idx];
    endfunction

    always @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            hist.delete();
            m_st   = 0;
            m_lvl  = 0;
            m_spur = 0;
        end else begin
            logic [3:0] h;
            bit         st;
            bit         vld;
            int         lv;
            hist.push_back({GS_bar, Y_bar});
            if (hist.size() > 32) void'(hist.pop_front());
            h  = back(3);
            st = 1;
            for (int i = 3; i < 3 + S; i++) if (back(i) != h) st = 0;
            vld    = st && !h[3];
            lv     = 7 - int'(h[2:0]);
            m_spur = 0;
            if (m_st == 0) begin
                if (vld) begin
                    m_st  = 1;
                    m_lvl = lv;
                end
            end else if (m_st == 1) begin
                if (irq_ack) m_st = 2;
                else if (st && h[3]) begin
                    m_st   = 0;
                    m_spur = 1;
                end else if (vld && lv != m_lvl) m_lvl = lv;
            end else begin
                if (eoi) m_st = 0;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] ev;
        logic [7:0] efc;
        ev  = 8'(8'h40 + m_lvl);
        efc = 8'(8'hFC + m_lvl);
        check("model_req",      {7'd0, irq_req},    {7'd0, m_st == 1});
        check("model_insvc",    {7'd0, in_service}, {7'd0, m_st == 2});
        check("model_spurious", {7'd0, spurious},   {7'd0, m_spur});
        check("model_vector",   irq_vector,          ev);
        check("model_fc_req",   {7'd0, fc_req},      {7'd0, m_st == 1});
        check("model_fc_vec",   fc_vector,           efc);
        if (irq_req) req_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r0;
        GS_bar  = 1'b1;
        Y_bar   = 3'b111;
        irq_ack = 1'b0;
        eoi     = 1'b0;
        rst_bar = 1'b0;
        repeat (3) tick();
        check("rst_req",    {7'd0, irq_req},    8'd0);
        check("rst_insvc",  {7'd0, in_service}, 8'd0);
        check("rst_spur",   {7'd0, spurious},   8'd0);
        check("rst_vector", irq_vector,         8'h40);
        rst_bar = 1'b1;
        repeat (3) tick();

        // level 5: latency, ack, eoi, re-entry, withdrawal
        GS_bar = 1'b0; Y_bar = 3'b010;
        repeat (6) tick();
        check("l5_req_edge6", {7'd0, irq_req}, 8'd0);
        tick();
        check("l5_req_edge7", {7'd0, irq_req}, 8'd1);
        check("l5_vector",    irq_vector,      8'h45);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("l5_ack_insvc", {7'd0, in_service}, 8'd1);
        check("l5_ack_req",   {7'd0, irq_req},    8'd0);
        repeat (3) tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        check("l5_eoi_insvc", {7'd0, in_service}, 8'd0);
        check("l5_eoi_req",   {7'd0, irq_req},    8'd0);
        tick();
        check("l5_reenter_req", {7'd0, irq_req}, 8'd1);
        GS_bar = 1'b1; Y_bar = 3'b111;
        repeat (7) tick();
        check("l5_withdraw_spur", {7'd0, spurious}, 8'd1);
        repeat (4) tick();

        // glitch: three low samples never reach PEND
        r0 = req_cnt;
        GS_bar = 1'b0; Y_bar = 3'b000;
        repeat (3) tick();
        GS_bar = 1'b1; Y_bar = 3'b111;
        repeat (12) tick();
        check("glitch_no_req", 8'(req_cnt - r0), 8'd0);

        // level 3 pending then level 6: vector updates, req held
        GS_bar = 1'b0; Y_bar = 3'b100;
        repeat (7) tick();
        check("l3_vector", irq_vector, 8'h43);
        Y_bar = 3'b001;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("l3_hold_req", {7'd0, irq_req}, 8'd1);
            check("l3_hold_vec", irq_vector,      8'h43);
        end
        tick();
        check("l6_req",    {7'd0, irq_req}, 8'd1);
        check("l6_vector", irq_vector,      8'h46);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        GS_bar = 1'b1; Y_bar = 3'b111;
        repeat (8) tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        repeat (2) tick();
        check("l6_done_insvc", {7'd0, in_service}, 8'd0);

        // level 2 pending, withdrawn -> single spurious pulse
        GS_bar = 1'b0; Y_bar = 3'b101;
        repeat (7) tick();
        check("l2_vector", irq_vector, 8'h42);
        GS_bar = 1'b1; Y_bar = 3'b111;
        repeat (6) tick();
        check("l2_pre_spur", {7'd0, spurious}, 8'd0);
        tick();
        check("l2_spur",     {7'd0, spurious}, 8'd1);
        check("l2_spur_req", {7'd0, irq_req},  8'd0);
        tick();
        check("l2_spur_end", {7'd0, spurious}, 8'd0);
        repeat (3) tick();

        // level 1 pending, ack lands on the same edge as the update to level 4
        GS_bar = 1'b0; Y_bar = 3'b110;
        repeat (7) tick();
        check("l1_vector", irq_vector, 8'h41);
        Y_bar = 3'b011;
        repeat (6) tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("ackchg_insvc", {7'd0, in_service}, 8'd1);
        check("ackchg_vec",   irq_vector,         8'h41);
        repeat (3) tick();
        check("ackchg_frozen", irq_vector, 8'h41);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        check("l4_after_eoi", irq_vector, 8'h44);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        GS_bar = 1'b1; Y_bar = 3'b111;
        repeat (8) tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        repeat (2) tick();

        // level 7: wrap with base 8'hFC, then async reset while in service
        GS_bar = 1'b0; Y_bar = 3'b000;
        repeat (7) tick();
        check("l7_vector",    irq_vector, 8'h47);
        check("l7_fc_vector", fc_vector,  8'h03);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("l7_insvc", {7'd0, in_service}, 8'd1);
        #2 rst_bar = 1'b0;
        #1;
        check("midrst_insvc",  {7'd0, in_service}, 8'd0);
        check("midrst_req",    {7'd0, irq_req},    8'd0);
        check("midrst_spur",   {7'd0, spurious},   8'd0);
        check("midrst_vector", irq_vector,         8'h40);
        check("midrst_fc_vec", fc_vector,          8'hFC);
        tick();
        rst_bar = 1'b1;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
